// File: rtl/if_ctrl_sequencer.sv
// Instruction-fetch control sequencer: redirect/flush/pause decode plus the trap
// entry/return FSM with pending-interrupt latching, non-nesting and a handler watchdog.
module if_ctrl_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_W   = 16,
    parameter int unsigned TIMEOUT_MAX = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       irq_req,
    input  logic       exc_req,
    input  logic       kernel_mode,
    input  logic       load_use,
    input  logic       branch_taken,
    input  logic       jump,
    input  logic       jr,
    input  logic       eret,
    output logic       IF_Flush,
    output logic       IF_Pause,
    output logic [2:0] PCSrc,
    output logic       intruption,
    output logic       exception,
    output logic       IRQ_BACKUP,
    output logic       IRQ_RECOVERY,
    output logic       in_handler,
    output logic       nested_err,
    output logic       watchdog
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_BACKUP,
        ST_HANDLER,
        ST_RECOVER
    } state_t;

    localparam logic [TIMEOUT_W-1:0] LP_TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_MAX);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [SYNC_STAGES-1:0] r_irq_sync;
    logic                   r_irq_prev;
    logic                   r_irq_pend;
    logic                   r_exc_pend;
    logic [2:0]             r_held;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic                   r_nested_err;
    logic                   r_watchdog;

    logic                   w_irq_edge;
    logic                   w_trap_pend;
    logic                   w_flow_state;
    logic                   w_exc_accept;
    logic                   w_serve_exc;
    logic                   w_serve_irq;
    logic [2:0]             w_redirect;
    logic                   w_flow_flush;
    logic                   w_flow_pause;
    logic [2:0]             w_flow_pcsrc;
    logic [TIMEOUT_W-1:0]   w_cnt_inc;

    assign w_irq_edge   = r_irq_sync[SYNC_STAGES-1] & ~r_irq_prev;
    assign w_trap_pend  = r_exc_pend | r_irq_pend;
    assign w_flow_state = (r_state == ST_RUN) || (r_state == ST_HANDLER);
    // Exceptions are only accepted outside a handler and outside kernel code.
    assign w_exc_accept = ((r_state == ST_RUN) || (r_state == ST_RECOVER)) && !kernel_mode;
    assign w_serve_exc  = (r_state == ST_BACKUP) && r_exc_pend;
    assign w_serve_irq  = (r_state == ST_BACKUP) && !r_exc_pend;
    assign w_redirect   = {jr, jump, branch_taken} | r_held;
    assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + TIMEOUT_W'(1);

    assign nested_err = r_nested_err;
    assign watchdog   = r_watchdog;

    always_comb begin
        w_flow_flush = 1'b0;
        w_flow_pause = load_use;
        w_flow_pcsrc = 3'b000;
        if (!load_use) begin
            w_flow_flush = |w_redirect;
            if (w_redirect[0]) begin
                w_flow_pcsrc = 3'b001;
            end else if (w_redirect[2]) begin
                w_flow_pcsrc = 3'b100;
            end else if (w_redirect[1]) begin
                w_flow_pcsrc = 3'b010;
            end
        end
    end

    // Outputs are forced low while reset is asserted, independent of the inputs.
    always_comb begin
        w_next_state = r_state;
        IF_Flush     = 1'b0;
        IF_Pause     = 1'b0;
        PCSrc        = 3'b000;
        intruption   = 1'b0;
        exception    = 1'b0;
        IRQ_BACKUP   = 1'b0;
        IRQ_RECOVERY = 1'b0;
        in_handler   = 1'b0;
        if (reset_b) begin
            case (r_state)
                ST_RUN: begin
                    IF_Flush = w_flow_flush;
                    IF_Pause = w_flow_pause;
                    PCSrc    = w_flow_pcsrc;
                    if (w_trap_pend && !load_use && !kernel_mode) begin
                        w_next_state = ST_BACKUP;
                    end
                end
                ST_BACKUP: begin
                    IRQ_BACKUP   = 1'b1;
                    IF_Flush     = 1'b1;
                    exception    = r_exc_pend;
                    intruption   = ~r_exc_pend;
                    w_next_state = ST_HANDLER;
                end
                ST_HANDLER: begin
                    in_handler = 1'b1;
                    IF_Flush   = w_flow_flush;
                    IF_Pause   = w_flow_pause;
                    PCSrc      = w_flow_pcsrc;
                    if (eret && !load_use) begin
                        w_next_state = ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    IRQ_RECOVERY = 1'b1;
                    w_next_state = ST_RUN;
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state      <= ST_RUN;
            r_irq_sync   <= '0;
            r_irq_prev   <= 1'b0;
            r_irq_pend   <= 1'b0;
            r_exc_pend   <= 1'b0;
            r_held       <= 3'b000;
            r_cnt        <= '0;
            r_nested_err <= 1'b0;
            r_watchdog   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], irq_req};
            r_irq_prev <= r_irq_sync[SYNC_STAGES-1];

            // A fresh edge arriving while the previous irq is served stays pending.
            if (w_irq_edge) begin
                r_irq_pend <= 1'b1;
            end else if (w_serve_irq) begin
                r_irq_pend <= 1'b0;
            end

            if (exc_req && w_exc_accept) begin
                r_exc_pend <= 1'b1;
            end else if (w_serve_exc) begin
                r_exc_pend <= 1'b0;
            end

            if (exc_req && !w_exc_accept) begin
                r_nested_err <= 1'b1;
            end

            if (w_flow_state && load_use) begin
                r_held <= r_held | {jr, jump, branch_taken};
            end else begin
                r_held <= 3'b000;
            end

            if (r_state == ST_HANDLER) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc >= LP_TIMEOUT_MAX) begin
                    r_watchdog <= 1'b1;
                end
            end else if ((r_state == ST_BACKUP) || (r_state == ST_RECOVER)) begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_if_ctrl_sequencer.sv
// Scoreboard bench for if_ctrl_sequencer: each scenario pushes the expected output
// vector when it drives a cycle and pops it when the outputs are sampled.
`timescale 1ns/1ps
module tb_if_ctrl_sequencer;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT_W   = 16;
    localparam int unsigned TIMEOUT_MAX = 8;

    // Stimulus bits: {irq_req, exc_req, kernel_mode, load_use, branch_taken, jump, jr, eret}
    localparam logic [7:0] S_NONE = 8'h00;
    localparam logic [7:0] S_IRQ  = 8'h80;
    localparam logic [7:0] S_EXC  = 8'h40;
    localparam logic [7:0] S_KERN = 8'h20;
    localparam logic [7:0] S_LU   = 8'h10;
    localparam logic [7:0] S_BR   = 8'h08;
    localparam logic [7:0] S_J    = 8'h04;
    localparam logic [7:0] S_JR   = 8'h02;
    localparam logic [7:0] S_ERET = 8'h01;

    // Output bits: {IF_Flush, IF_Pause, PCSrc[2:0], intruption, exception,
    //               IRQ_BACKUP, IRQ_RECOVERY, in_handler, nested_err, watchdog}
    localparam logic [11:0] E_NONE  = 12'h000;
    localparam logic [11:0] E_FLUSH = 12'h800;
    localparam logic [11:0] E_PAUSE = 12'h400;
    localparam logic [11:0] E_PC_JR = 12'h200;
    localparam logic [11:0] E_PC_J  = 12'h100;
    localparam logic [11:0] E_PC_B  = 12'h080;
    localparam logic [11:0] E_INT   = 12'h040;
    localparam logic [11:0] E_EXC   = 12'h020;
    localparam logic [11:0] E_BK    = 12'h010;
    localparam logic [11:0] E_RC    = 12'h008;
    localparam logic [11:0] E_IH    = 12'h004;
    localparam logic [11:0] E_NE    = 12'h002;
    localparam logic [11:0] E_WD    = 12'h001;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       irq_req = 1'b0, exc_req = 1'b0, kernel_mode = 1'b0, load_use = 1'b0;
    logic       branch_taken = 1'b0, jump = 1'b0, jr = 1'b0, eret = 1'b0;
    logic       IF_Flush, IF_Pause, intruption, exception, IRQ_BACKUP, IRQ_RECOVERY;
    logic       in_handler, nested_err, watchdog;
    logic [2:0] PCSrc;
    logic [11:0] obsVec;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } sb_item_t;

    sb_item_t sbQueue[$];
    int nChecks = 0;
    int nPassed = 0;

    always #5 clk = ~clk;

    assign obsVec = {IF_Flush, IF_Pause, PCSrc, intruption, exception,
                     IRQ_BACKUP, IRQ_RECOVERY, in_handler, nested_err, watchdog};

    if_ctrl_sequencer #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_MAX (TIMEOUT_MAX)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .irq_req      (irq_req),
        .exc_req      (exc_req),
        .kernel_mode  (kernel_mode),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .eret         (eret),
        .IF_Flush     (IF_Flush),
        .IF_Pause     (IF_Pause),
        .PCSrc        (PCSrc),
        .intruption   (intruption),
        .exception    (exception),
        .IRQ_BACKUP   (IRQ_BACKUP),
        .IRQ_RECOVERY (IRQ_RECOVERY),
        .in_handler   (in_handler),
        .nested_err   (nested_err),
        .watchdog     (watchdog)
    );

    task automatic drive_cycle(input logic [7:0] stim, input logic [11:0] exp, input string name);
        sb_item_t item;
        @(posedge clk);
        #1;
        {irq_req, exc_req, kernel_mode, load_use, branch_taken, jump, jr, eret} = stim;
        item.name = name;
        item.exp  = exp;
        sbQueue.push_back(item);
    endtask

    task automatic test_reset();
        sb_item_t item;
        #2;
        sbQueue.push_back('{"reset_initial", E_NONE});
        item = sbQueue.pop_front();
        nChecks++;
        if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
        else nPassed++;
        #1;
        {branch_taken, jump} = 2'b11;
        sbQueue.push_back('{"reset_gated_outputs", E_NONE});
        #1;
        item = sbQueue.pop_front();
        nChecks++;
        if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
        else nPassed++;
        {branch_taken, jump} = 2'b00;
        @(negedge clk);
        #1 reset_b = 1'b1;
        drive_cycle(S_NONE, E_NONE, "reset_release");
        @(negedge clk);
        item = sbQueue.pop_front();
        nChecks++;
        if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
        else nPassed++;
    endtask

    task automatic test_branch_priority();
        logic [7:0]  stim [6] = '{S_BR|S_JR, S_JR, S_J, S_BR|S_J|S_JR, S_J|S_JR, S_NONE};
        logic [11:0] expv [6] = '{E_FLUSH|E_PC_B, E_FLUSH|E_PC_JR, E_FLUSH|E_PC_J,
                                  E_FLUSH|E_PC_B, E_FLUSH|E_PC_JR, E_NONE};
        sb_item_t item;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(stim[i], expv[i], $sformatf("branch_prio[%0d]", i));
            @(negedge clk);
            item = sbQueue.pop_front();
            nChecks++;
            if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
            else nPassed++;
        end
    endtask

    task automatic test_load_use();
        logic [7:0]  stim [6] = '{S_LU|S_J, S_LU|S_J, S_J, S_LU|S_BR|S_JR, S_BR|S_JR, S_NONE};
        logic [11:0] expv [6] = '{E_PAUSE, E_PAUSE, E_FLUSH|E_PC_J, E_PAUSE, E_FLUSH|E_PC_B, E_NONE};
        sb_item_t item;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(stim[i], expv[i], $sformatf("load_use[%0d]", i));
            @(negedge clk);
            item = sbQueue.pop_front();
            nChecks++;
            if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
            else nPassed++;
        end
    endtask

    task automatic test_irq_entry();
        logic [7:0]  stim [12] = '{S_IRQ, S_NONE, S_NONE, S_NONE, S_NONE, S_NONE,
                                   S_J, S_ERET|S_LU, S_ERET, S_BR, S_NONE, S_NONE};
        logic [11:0] expv [12] = '{E_NONE, E_NONE, E_NONE, E_NONE, E_FLUSH|E_INT|E_BK, E_IH,
                                   E_FLUSH|E_PC_J|E_IH, E_PAUSE|E_IH, E_IH, E_RC, E_NONE, E_NONE};
        sb_item_t item;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(stim[i], expv[i], $sformatf("irq_entry[%0d]", i));
            @(negedge clk);
            item = sbQueue.pop_front();
            nChecks++;
            if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
            else nPassed++;
        end
    endtask

    task automatic test_exc_irq_same();
        logic [7:0]  stim [15] = '{S_IRQ, S_NONE, S_EXC, S_NONE, S_NONE, S_NONE, S_ERET, S_NONE,
                                   S_NONE, S_NONE, S_NONE, S_ERET, S_NONE, S_NONE, S_NONE};
        logic [11:0] expv [15] = '{E_NONE, E_NONE, E_NONE, E_NONE, E_FLUSH|E_EXC|E_BK, E_IH, E_IH, E_RC,
                                   E_NONE, E_FLUSH|E_INT|E_BK, E_IH, E_IH, E_RC, E_NONE, E_NONE};
        sb_item_t item;
        for (int i = 0; i < 15; i++) begin
            drive_cycle(stim[i], expv[i], $sformatf("exc_irq_same[%0d]", i));
            @(negedge clk);
            item = sbQueue.pop_front();
            nChecks++;
            if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
            else nPassed++;
        end
    endtask

    task automatic test_nested_watchdog();
        logic [7:0]  stim [13] = '{S_EXC, S_NONE, S_NONE, S_NONE, S_EXC, S_NONE, S_NONE,
                                   S_NONE, S_NONE, S_NONE, S_NONE, S_NONE, S_NONE};
        logic [11:0] expv [13] = '{E_NONE, E_NONE, E_FLUSH|E_EXC|E_BK, E_IH, E_IH,
                                   E_IH|E_NE, E_IH|E_NE, E_IH|E_NE, E_IH|E_NE, E_IH|E_NE,
                                   E_IH|E_NE, E_IH|E_NE|E_WD, E_IH|E_NE|E_WD};
        sb_item_t item;
        for (int i = 0; i < 13; i++) begin
            drive_cycle(stim[i], expv[i], $sformatf("nested_watchdog[%0d]", i));
            @(negedge clk);
            item = sbQueue.pop_front();
            nChecks++;
            if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
            else nPassed++;
        end
    endtask

    task automatic test_reset_mid_handler();
        sb_item_t item;
        drive_cycle(S_BR|S_J, E_FLUSH|E_PC_B|E_IH|E_NE|E_WD, "pre_reset_handler");
        @(negedge clk);
        item = sbQueue.pop_front();
        nChecks++;
        if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
        else nPassed++;
        #1 reset_b = 1'b0;
        sbQueue.push_back('{"reset_async_mid_handler", E_NONE});
        #1;
        item = sbQueue.pop_front();
        nChecks++;
        if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
        else nPassed++;
        drive_cycle(S_NONE, E_NONE, "reset_held");
        @(negedge clk);
        item = sbQueue.pop_front();
        nChecks++;
        if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
        else nPassed++;
        #1 reset_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(S_NONE, E_NONE, $sformatf("post_reset_idle[%0d]", i));
            @(negedge clk);
            item = sbQueue.pop_front();
            nChecks++;
            if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
            else nPassed++;
        end
    endtask

    task automatic test_kernel_mode();
        logic [7:0]  stim [11] = '{S_KERN|S_EXC, S_KERN, S_KERN, S_KERN|S_IRQ, S_KERN, S_KERN,
                                   S_KERN, S_KERN, S_NONE, S_NONE, S_NONE};
        logic [11:0] expv [11] = '{E_NONE, E_NE, E_NE, E_NE, E_NE, E_NE, E_NE, E_NE, E_NE,
                                   E_FLUSH|E_INT|E_BK|E_NE, E_IH|E_NE};
        sb_item_t item;
        for (int i = 0; i < 11; i++) begin
            drive_cycle(stim[i], expv[i], $sformatf("kernel_mode[%0d]", i));
            @(negedge clk);
            item = sbQueue.pop_front();
            nChecks++;
            if (obsVec !== item.exp) $display("[TB] FAIL %s: got %b expected %b", item.name, obsVec, item.exp);
            else nPassed++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_branch_priority();
        test_load_use();
        test_irq_entry();
        test_exc_irq_same();
        test_nested_watchdog();
        test_reset_mid_handler();
        test_kernel_mode();
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
